// File: rtl/lock_key_pkg.sv
// Shared types and constants for the c432 key-load controller and its CRC engine.
package lock_key_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_CRC,
    CHECK,
    ARMED,
    LOCKOUT
  } state_t;

  localparam logic [7:0] CRC_POLY = 8'h07;
  localparam logic [7:0] CRC_INIT = 8'h00;

  localparam int P_LSB = 22;
  localparam int X_LSB = 0;

  // One MSB-first step of CRC-8 (x^8+x^2+x+1), no reflection.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ (((crc[7] ^ b) == 1'b1) ? CRC_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator; clr has priority over en.
module crc8_serial
  import lock_key_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       data,
  output logic [7:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc8_step(crc, data);
    end
  end

endmodule

// File: rtl/lock_key_ctrl.sv
// Serial key loader for the key-locked c432: CRC-checked shadow key, commit to
// the core's key inputs, lockout after repeated bad loads.
module lock_key_ctrl
  import lock_key_pkg::*;
#(
  parameter int               KEY_W     = 26,
  parameter int               MAX_FAIL  = 3,
  parameter logic [KEY_W-1:0] KEY_RESET = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             key_bit,
  input  logic             key_vld,
  output logic             key_rdy,
  input  logic             commit,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  output logic             lockout
);

  localparam int CNT_W  = $clog2(KEY_W + 1);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  state_t             state;
  state_t             state_nx;
  logic [KEY_W-1:0]   shadow;
  logic [7:0]         rx_crc;
  logic [7:0]         crc;
  logic [CNT_W-1:0]   cnt;
  logic [FAIL_W-1:0]  fail_cnt;
  logic [FAIL_W-1:0]  fail_inc;
  logic               xfer;
  logic               start_ok;
  logic               crc_clr;
  logic               crc_en;
  logic               crc_ok;
  logic               key_last;
  logic               crc_last;

  assign xfer     = key_vld & key_rdy;
  assign start_ok = load_start & (state inside {IDLE, LOAD_KEY, LOAD_CRC, ARMED});
  assign crc_clr  = start_ok;
  // A bit arriving together with a restart is discarded, so it must not reach the CRC.
  assign crc_en   = xfer & (state == LOAD_KEY) & ~load_start;
  assign crc_ok   = (rx_crc == crc);
  assign key_last = (cnt == CNT_W'(KEY_W - 1));
  assign crc_last = (cnt == CNT_W'(7));
  assign fail_inc = (fail_cnt == FAIL_W'(MAX_FAIL)) ? fail_cnt : fail_cnt + 1'b1;

  crc8_serial u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .data  (key_bit),
    .crc   (crc)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (load_start) state_nx = LOAD_KEY;
      LOAD_KEY: begin
        if (load_start)             state_nx = LOAD_KEY;
        else if (xfer && key_last)  state_nx = LOAD_CRC;
      end
      LOAD_CRC: begin
        if (load_start)             state_nx = LOAD_KEY;
        else if (xfer && crc_last)  state_nx = CHECK;
      end
      CHECK: begin
        if (crc_ok)                              state_nx = ARMED;
        else if (fail_inc == FAIL_W'(MAX_FAIL))  state_nx = LOCKOUT;
        else                                     state_nx = IDLE;
      end
      ARMED: begin
        if (load_start)   state_nx = LOAD_KEY;
        else if (commit)  state_nx = IDLE;
      end
      LOCKOUT:  state_nx = LOCKOUT;
      default:  state_nx = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_out   <= KEY_RESET;
      key_valid <= 1'b0;
      key_rdy   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      lockout   <= 1'b0;
      fail_cnt  <= '0;
      shadow    <= '0;
      rx_crc    <= 8'h00;
      cnt       <= '0;
    end else begin
      state   <= state_nx;
      key_rdy <= (state_nx == LOAD_KEY) || (state_nx == LOAD_CRC);
      busy    <= (state_nx == LOAD_KEY) || (state_nx == LOAD_CRC) || (state_nx == CHECK);
      lockout <= (state_nx == LOCKOUT);

      if (start_ok) begin
        shadow <= '0;
        rx_crc <= 8'h00;
        cnt    <= '0;
        err    <= 1'b0;
      end else begin
        case (state)
          LOAD_KEY: if (xfer) begin
            shadow <= {shadow[KEY_W-2:0], key_bit};
            cnt    <= key_last ? '0 : cnt + 1'b1;
          end
          LOAD_CRC: if (xfer) begin
            rx_crc <= {rx_crc[6:0], key_bit};
            cnt    <= crc_last ? '0 : cnt + 1'b1;
          end
          CHECK: begin
            if (crc_ok) begin
              fail_cnt <= '0;
            end else begin
              err      <= 1'b1;
              fail_cnt <= fail_inc;
            end
          end
          ARMED: if (commit) begin
            key_out   <= shadow;
            key_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  a_rdy_only_loading : assert property (@(posedge clk) disable iff (!rst_n)
    key_rdy |-> (state == LOAD_KEY || state == LOAD_CRC));

  a_lockout_sticky : assert property (@(posedge clk) disable iff (!rst_n)
    lockout |=> lockout);

endmodule

// File: tb/tb_lock_key_ctrl.sv
// Randomized bench for lock_key_ctrl against a transaction-level model of the key loader.
module tb_lock_key_ctrl;

  localparam int KEY_W    = 26;
  localparam int MAX_FAIL = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_start = 1'b0;
  logic             key_bit = 1'b0;
  logic             key_vld = 1'b0;
  logic             commit = 1'b0;
  logic             key_rdy;
  logic [KEY_W-1:0] key_out;
  logic             key_valid;
  logic             busy;
  logic             err;
  logic             lockout;

  always #5 clk = ~clk;

  lock_key_ctrl #(.KEY_W(KEY_W), .MAX_FAIL(MAX_FAIL), .KEY_RESET('0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .key_bit    (key_bit),
    .key_vld    (key_vld),
    .key_rdy    (key_rdy),
    .commit     (commit),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .err        (err),
    .lockout    (lockout)
  );

  int checks   = 0;
  int failures = 0;

  // Model of what the outside world should see.
  logic [KEY_W-1:0] m_key    = '0;
  logic [KEY_W-1:0] m_shadow = '0;
  bit               m_valid  = 1'b0;
  bit               m_err    = 1'b0;
  bit               m_lock   = 1'b0;
  bit               m_armed  = 1'b0;
  int               m_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC as the remainder of key * x^8 divided by x^8+x^2+x+1.
  function automatic logic [7:0] ref_crc(input logic [KEY_W-1:0] k);
    logic [33:0] m;
    m = {k, 8'h00};
    for (int i = 33; i >= 8; i--)
      if (m[i]) m = m ^ (34'h107 << (i - 8));
    return m[7:0];
  endfunction

  task automatic check_state(input string tag, input bit exp_busy, input bit exp_rdy);
    chk({tag, ".key_out"},   32'(key_out),   32'(m_key));
    chk({tag, ".key_valid"}, 32'(key_valid), 32'(m_valid));
    chk({tag, ".err"},       32'(err),       32'(m_err));
    chk({tag, ".lockout"},   32'(lockout),   32'(m_lock));
    chk({tag, ".busy"},      32'(busy),      32'(exp_busy));
    chk({tag, ".key_rdy"},   32'(key_rdy),   32'(exp_rdy));
  endtask

  task automatic model_reset();
    m_key = '0; m_shadow = '0; m_valid = 0; m_err = 0; m_lock = 0; m_armed = 0; m_fails = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    load_start = 0; commit = 0; key_vld = 0;
    #1 model_reset();
    check_state("reset", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Presents the first nbits of bits (MSB first); returns after the last transfer edge.
  task automatic stream(input logic [33:0] bits, input int nbits, input bit gaps, output bit ok);
    int sent = 0;
    int waitc = 0;
    ok = 1'b1;
    while (sent < nbits) begin
      @(negedge clk);
      if (gaps && $urandom_range(0, 2) == 0) begin
        key_vld = 1'b0;
        key_bit = 1'($urandom_range(0, 1));
      end else begin
        key_vld = 1'b1;
        key_bit = bits[33 - sent];
      end
      if (!key_rdy) waitc++;
      else if (key_vld) sent++;
      if (waitc > 50) begin
        chk("rdy_timeout", 32'(key_rdy), 32'd1);
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk);
    key_vld = 1'b0;
  endtask

  task automatic do_load(input logic [KEY_W-1:0] key, input logic [7:0] crc,
                         input bit gaps, input int abort_at, input bit skip_start);
    bit ok;
    if (!skip_start) begin
      @(negedge clk);
      load_start = 1'b1;
      @(negedge clk);
      load_start = 1'b0;
      m_err = 0; m_armed = 0;
      check_state("start", 1, 1);
    end
    if (abort_at > 0) begin
      stream({KEY_W'($urandom), 8'($urandom)}, abort_at, gaps, ok);
      if (!ok) return;
      load_start = 1'b1; key_vld = 1'b1; key_bit = 1'b1;
      @(negedge clk);
      load_start = 1'b0; key_vld = 1'b0;
      check_state("restart", 1, 1);
    end
    stream({key, crc}, 34, gaps, ok);
    if (!ok) return;
    chk("check.busy", 32'(busy), 32'd1);
    chk("check.key_rdy", 32'(key_rdy), 32'd0);
    @(negedge clk);
    if (crc == ref_crc(key)) begin
      m_fails = 0; m_armed = 1; m_shadow = key;
    end else begin
      m_err = 1;
      if (m_fails < MAX_FAIL) m_fails++;
      if (m_fails >= MAX_FAIL) m_lock = 1;
    end
    check_state("done", 0, 0);
  endtask

  task automatic do_commit();
    @(negedge clk);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    if (m_armed && !m_lock) begin
      m_key = m_shadow; m_valid = 1; m_armed = 0;
    end
    check_state("commit", 0, 0);
  endtask

  task automatic start_and_commit();
    @(negedge clk);
    load_start = 1'b1; commit = 1'b1;
    @(negedge clk);
    load_start = 1'b0; commit = 1'b0;
    m_armed = 0; m_err = 0;
    check_state("start_commit", 1, 1);
  endtask

  task automatic poke_locked();
    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    check_state("locked_start", 0, 0);
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    check_state("locked_commit", 0, 0);
  endtask

  function automatic logic [7:0] pick_crc(input logic [KEY_W-1:0] k, input bit good);
    return good ? ref_crc(k) : (ref_crc(k) ^ 8'($urandom_range(1, 255)));
  endfunction

  initial begin
    bit ok;
    logic [KEY_W-1:0] k;
    repeat (3) @(negedge clk);
    check_state("por", 0, 0);
    rst_n = 1'b1;

    do_load(26'h0, 8'h00, 0, 0, 0);
    do_commit();
    do_load(26'h1, 8'h07, 0, 0, 0);
    do_commit();
    do_load(26'h2, 8'h0E, 0, 0, 0);
    do_commit();
    do_load(26'h0, 8'h01, 0, 0, 0);

    do_load(26'h1, 8'h07, 0, 0, 0);
    for (int i = 0; i < 3; i++) do_load(26'h3, 8'h00, 0, 0, 0);
    poke_locked();
    do_reset();

    do_load(26'h1, 8'h07, 0, 10, 0);
    do_commit();
    do_load(26'h1, 8'h07, 1, 10, 0);
    do_commit();

    do_load(26'h2, 8'h0E, 0, 0, 0);
    start_and_commit();
    do_load(26'h5, ref_crc(26'h5), 1, 0, 1);
    do_commit();

    @(negedge clk);
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    stream({26'h2AAAAAA, 8'h00}, 10, 0, ok);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_state("midload_reset", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int it = 0; it < 40; it++) begin
      if (m_lock) begin
        poke_locked();
        do_reset();
      end else begin
        k = KEY_W'($urandom);
        do_load(k, pick_crc(k, $urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : 0, 0);
        if (m_armed) begin
          if ($urandom_range(0, 4) == 0) begin
            start_and_commit();
            k = KEY_W'($urandom);
            do_load(k, pick_crc(k, 1), 1, 0, 1);
          end
          if ($urandom_range(0, 2) != 0) do_commit();
        end else if ($urandom_range(0, 3) == 0) begin
          do_commit();
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lock_key_ctrl.md
Name: lock_key_ctrl

Overview:
- Sequencing controller for the key-locked c432 core.
- Receives a serial 26-bit unlock key plus an 8-bit CRC over a valid/ready bit stream, checks the CRC, and holds the key in a shadow register.
- A separate commit pulse drives the checked key onto the core's key inputs: four mux-select bits and 22 XOR key bits.
- Repeated bad loads lock the controller out until reset.

Parameters:
- KEY_W, 26, key length; bits [25:22] drive p4..p1, bits [21:0] drive X_22..X_1.
- MAX_FAIL, 3, consecutive CRC failures that force LOCKOUT.
- KEY_RESET, 26'h0, key_out value after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse: begin a key load.
- key_bit  in  1  serial data bit, MSB first.
- key_vld  in  1  key_bit valid.
- key_rdy  out  1  controller accepts a bit this cycle.
- commit  in  1  one-cycle pulse: apply the checked key.
- key_out  out  KEY_W  key applied to the locked core.
- key_valid  out  1  key_out holds a committed, CRC-checked key.
- busy  out  1  high in LOAD_KEY, LOAD_CRC and CHECK.
- err  out  1  sticky CRC-mismatch flag; cleared by an accepted load_start.
- lockout  out  1  high in LOCKOUT.

Behaviour:
- Reset (async assert, sync deassert): state=IDLE; key_out=KEY_RESET; key_valid=0, key_rdy=0, busy=0, err=0, lockout=0; fail_cnt=0; shadow=0; crc=0x00; bit counter=0.
- A bit transfers on a cycle where key_vld & key_rdy. key_rdy=1 only in LOAD_KEY and LOAD_CRC, and is a registered function of state.
- IDLE: load_start -> LOAD_KEY. On the same edge: clear shadow, crc=0x00, bit counter=0, err=0.
- LOAD_KEY: each transfer shifts the bit into shadow LSB-side (first bit ends at bit 25) and updates crc. After the KEY_W-th transfer -> LOAD_CRC with counter=0.
- CRC update per bit: poly x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR. Compute fb=crc[7]^bit, then crc=(crc<<1)^(fb?0x07:0).
- LOAD_CRC: 8 transfers, MSB first, into rx_crc. After the 8th -> CHECK.
- CHECK (one cycle, no handshake):
  - rx_crc==crc: fail_cnt=0, -> ARMED.
  - Mismatch: err=1, fail_cnt+=1, -> IDLE. If fail_cnt reaches MAX_FAIL, -> LOCKOUT instead.
- ARMED:
  - commit -> key_out=shadow, key_valid=1 on that edge, -> IDLE.
  - load_start -> LOAD_KEY as in IDLE.
- Latency: last CRC bit edge -> CHECK one cycle later -> ARMED/IDLE/LOCKOUT the following edge. commit in ARMED updates key_out on the same edge.
- key_out and key_valid change only on a successful commit or reset. A new load, a failure or LOCKOUT never disturbs the previously committed key.
- LOCKOUT: lockout=1, key_rdy=0. load_start and commit are ignored. Exit only via rst_n. key_out is held.
- Boundaries:
  - load_start during LOAD_KEY/LOAD_CRC restarts the load: clears shadow, crc and counter, without touching fail_cnt. A bit presented on that same cycle is discarded.
  - load_start together with commit in ARMED: load_start wins and commit is dropped.
  - commit outside ARMED is ignored.
  - key_vld low stalls indefinitely, with no timeout.
  - fail_cnt saturates at MAX_FAIL.
  - rst_n asserted mid-load returns every output to its reset value immediately.

Decomposition:
- Package lock_key_pkg holds:
  - state enum: IDLE, LOAD_KEY, LOAD_CRC, CHECK, ARMED, LOCKOUT;
  - CRC_POLY=8'h07, CRC_INIT=8'h00;
  - field offsets P_LSB=22, X_LSB=0.
- One sub-module crc8_serial: inputs clk, rst_n, clr, en, bit; output crc[7:0]. Reused by the deobfuscation test harness.

Test Plan:
- Reset, then load 26'h0000000 with CRC 0x00, then commit -> key_rdy high for 34 transfers; ARMED two cycles after the last bit; key_out=0, key_valid=1, err=0.
- Load 26'h0000001 with CRC 0x07, then load 26'h0000002 with CRC 0x0E; commit after each -> key_out=26'h1 then 26'h2, with key_valid held at 1 throughout.
- After committing 26'h2, load 26'h0 with CRC 0x01 -> err=1, state IDLE, key_out stays 26'h2, key_valid=1.
- Three consecutive bad CRCs -> lockout=1 after the third CHECK; further load_start and commit have no effect; rst_n low -> key_out=KEY_RESET, lockout=0.
- load_start after 10 key bits, then a clean 26'h1 / CRC 0x07 load -> accepted, with no err. Random key_vld gaps give the same result.
- In ARMED, assert load_start and commit in the same cycle -> key_out unchanged, state LOAD_KEY, busy=1.
